// File: rtl/reg_cmd_bridge.sv
// Byte-serial command bridge: parses 'W' addr hi lo / 'R' addr commands from a
// receive stream, drives a simple register port, and returns ack/read bytes.
module reg_cmd_bridge #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  w_addr_o,
    output logic [15:0] w_data_o,
    output logic        write_enable_o,
    output logic [7:0]  r_addr_o,
    input  logic [15:0] r_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        err_o
);
    typedef enum logic [3:0] {
        IDLE, ADDR, DHI, DLO, WRITE, RD_WAIT, RD_CAP, TX_HI, TX_LO, TX_ACK
    } state_t;

    localparam logic [7:0]  CMD_W   = 8'h57;
    localparam logic [7:0]  CMD_R   = 8'h52;
    localparam logic [7:0]  BYTE_OK = 8'h4B;
    localparam logic [7:0]  BYTE_NK = 8'h15;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  w_addr_q, w_addr_d;
    logic [15:0] w_data_q, w_data_d;
    logic [7:0]  r_addr_q, r_addr_d;
    logic [15:0] rd_q, rd_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        accept;
    logic        cnt_expired;
    logic        rx_state;

    assign rx_state       = (state_q == IDLE) || (state_q == ADDR) ||
                            (state_q == DHI)  || (state_q == DLO);
    assign rx_ready_o     = rx_state & ~reset;
    assign accept         = rx_valid_i & rx_ready_o;
    assign cnt_expired    = (cnt_q == CNT_LAST);
    assign write_enable_o = (state_q == WRITE);
    assign tx_valid_o     = (state_q == TX_HI) || (state_q == TX_LO) || (state_q == TX_ACK);
    assign w_addr_o       = w_addr_q;
    assign w_data_o       = w_data_q;
    assign r_addr_o       = r_addr_q;
    assign tx_data_o      = tx_data_q;
    assign err_o          = err_q;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_hi_d  = data_hi_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        r_addr_d   = r_addr_q;
        rd_d       = rd_q;
        tx_data_d  = tx_data_q;
        cnt_d      = '0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rx_data_i == CMD_W) begin
                        is_write_d = 1'b1;
                        state_d    = ADDR;
                    end else if (rx_data_i == CMD_R) begin
                        is_write_d = 1'b0;
                        state_d    = ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (accept) begin
                    addr_d = rx_data_i;
                    // Upper nibble must be zero; 13..15 are read-only.
                    if ((rx_data_i[7:4] != 4'h0) ||
                        (is_write_q && (rx_data_i[3:0] >= 4'd13))) begin
                        err_d     = 1'b1;
                        tx_data_d = BYTE_NK;
                        state_d   = TX_ACK;
                    end else if (is_write_q) begin
                        state_d = DHI;
                    end else begin
                        r_addr_d = rx_data_i;
                        state_d  = RD_WAIT;
                    end
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DHI: begin
                if (accept) begin
                    data_hi_d = rx_data_i;
                    state_d   = DLO;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DLO: begin
                if (accept) begin
                    w_addr_d = addr_q;
                    w_data_d = {data_hi_q, rx_data_i};
                    state_d  = WRITE;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WRITE: begin
                tx_data_d = BYTE_OK;
                state_d   = TX_ACK;
            end
            RD_WAIT: state_d = RD_CAP;
            RD_CAP: begin
                rd_d      = r_data_i;
                tx_data_d = r_data_i[15:8];
                state_d   = TX_HI;
            end
            TX_HI: begin
                if (tx_ready_i) begin
                    tx_data_d = rd_q[7:0];
                    state_d   = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_ready_i) state_d = IDLE;
            end
            TX_ACK: begin
                if (tx_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_hi_q  <= '0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            r_addr_q   <= '0;
            rd_q       <= '0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_hi_q  <= data_hi_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            r_addr_q   <= r_addr_d;
            rd_q       <= rd_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Directed bench for reg_cmd_bridge: write, read, rejects, timeout, backpressure, reset.
module tb_reg_cmd_bridge;
    localparam int unsigned TO = 8;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  w_addr_o;
    logic [15:0] w_data_o;
    logic        write_enable_o;
    logic [7:0]  r_addr_o;
    logic [15:0] r_data_i = '0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic        err_o;

    int n_chk = 0;
    int n_err = 0;
    int we_cnt = 0;
    int err_cnt = 0;
    logic [7:0]  we_addr = '0;
    logic [15:0] we_data = '0;
    logic [7:0]  tx_q[$];

    reg_cmd_bridge #(.TIMEOUT(TO)) dut (
        .clk_in(clk_in), .reset(reset),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .w_addr_o(w_addr_o), .w_data_o(w_data_o), .write_enable_o(write_enable_o),
        .r_addr_o(r_addr_o), .r_data_i(r_data_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .err_o(err_o)
    );

    always #5 clk_in = ~clk_in;

    // Register file model: data valid one clock after the address is sampled.
    always @(posedge clk_in)
        r_data_i <= (r_addr_o == 8'h03) ? 16'hBEEF : {8'hA5, r_addr_o};

    always @(negedge clk_in) begin
        if (write_enable_o) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= w_addr_o;
            we_data <= w_data_o;
        end
        if (err_o) err_cnt <= err_cnt + 1;
        if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        while (!rx_ready_o && k < 50) begin
            tick();
            k++;
        end
        check("rx_ready_wait", {31'd0, rx_ready_o}, 32'd1);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < n && k < 100) begin
            tick();
            k++;
        end
        check("tx_count", tx_q.size(), n);
    endtask

    int we0, er0, tx0;

    task automatic snap();
        we0 = we_cnt;
        er0 = err_cnt;
        tx0 = tx_q.size();
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_rx_ready", {31'd0, rx_ready_o}, 0);
        check("rst_tx_valid", {31'd0, tx_valid_o}, 0);
        check("rst_we", {31'd0, write_enable_o}, 0);
        check("rst_w_data", {16'd0, w_data_o}, 0);
        check("rst_tx_data", {24'd0, tx_data_o}, 0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_rx_ready", {31'd0, rx_ready_o}, 1);
        $display("txn reset done");

        // Write 57 01 12 34
        snap();
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        check("wr_we_latency", {31'd0, write_enable_o}, 1);
        check("wr_rx_ready_busy", {31'd0, rx_ready_o}, 0);
        tick();
        check("wr_we_one_cycle", {31'd0, write_enable_o}, 0);
        wait_tx(tx0 + 1);
        check("wr_we_count", we_cnt - we0, 1);
        check("wr_addr", {24'd0, we_addr}, 32'h01);
        check("wr_data", {16'd0, we_data}, 32'h1234);
        check("wr_ack", {24'd0, tx_q[tx0]}, 32'h4B);
        check("wr_no_err", err_cnt - er0, 0);
        check("wr_addr_hold", {24'd0, w_addr_o}, 32'h01);
        $display("txn write 57 01 12 34 done");

        // Read 52 03 with latency check
        snap();
        send_byte(8'h52); send_byte(8'h03);
        check("rd_lat_1", {31'd0, tx_valid_o}, 0);
        tick();
        check("rd_lat_2", {31'd0, tx_valid_o}, 0);
        tick();
        check("rd_lat_3", {31'd0, tx_valid_o}, 1);
        check("rd_hi_now", {24'd0, tx_data_o}, 32'hBE);
        wait_tx(tx0 + 2);
        check("rd_hi", {24'd0, tx_q[tx0]}, 32'hBE);
        check("rd_lo", {24'd0, tx_q[tx0+1]}, 32'hEF);
        check("rd_no_err", err_cnt - er0, 0);
        $display("txn read 52 03 done");

        // Reject write to 0x0E, then a stray byte is parsed from IDLE
        snap();
        send_byte(8'h57); send_byte(8'h0E);
        wait_tx(tx0 + 1);
        check("rej_w_nak", {24'd0, tx_q[tx0]}, 32'h15);
        check("rej_w_err", err_cnt - er0, 1);
        send_byte(8'h12);
        repeat (3) tick();
        check("rej_w_stray_err", err_cnt - er0, 2);
        check("rej_w_no_tx", tx_q.size() - tx0, 1);
        check("rej_w_no_we", we_cnt - we0, 0);
        $display("txn reject 57 0E done");

        // Reject read of 0x20
        snap();
        send_byte(8'h52); send_byte(8'h20);
        wait_tx(tx0 + 1);
        tick();
        check("rej_r_nak", {24'd0, tx_q[tx0]}, 32'h15);
        check("rej_r_err", err_cnt - er0, 1);
        $display("txn reject 52 20 done");

        // Timeout after 57 02, then 52 02 handled normally
        snap();
        send_byte(8'h57); send_byte(8'h02);
        repeat (TO - 1) tick();
        check("to_not_yet", err_cnt - er0, 0);
        repeat (3) tick();
        check("to_err", err_cnt - er0, 1);
        check("to_no_tx", tx_q.size() - tx0, 0);
        send_byte(8'h52); send_byte(8'h02);
        wait_tx(tx0 + 2);
        check("to_rd_hi", {24'd0, tx_q[tx0]}, 32'hA5);
        check("to_rd_lo", {24'd0, tx_q[tx0+1]}, 32'h02);
        $display("txn timeout then read 52 02 done");

        // Byte arriving on the last counter cycle wins over the timeout
        snap();
        send_byte(8'h57); send_byte(8'h02);
        repeat (TO - 1) tick();
        send_byte(8'h12);
        send_byte(8'h34);
        wait_tx(tx0 + 1);
        check("edge_no_err", err_cnt - er0, 0);
        check("edge_we", we_cnt - we0, 1);
        check("edge_data", {16'd0, we_data}, 32'h1234);
        check("edge_addr", {24'd0, we_addr}, 32'h02);
        $display("txn timeout boundary write done");

        // Backpressure on read
        snap();
        tx_ready_i = 1'b0;
        send_byte(8'h52); send_byte(8'h03);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, tx_valid_o}, 1);
            check("bp_data", {24'd0, tx_data_o}, 32'hBE);
            check("bp_rx_ready", {31'd0, rx_ready_o}, 0);
            tick();
        end
        tx_ready_i = 1'b1;
        wait_tx(tx0 + 2);
        check("bp_hi", {24'd0, tx_q[tx0]}, 32'hBE);
        check("bp_lo", {24'd0, tx_q[tx0+1]}, 32'hEF);
        tick(); tick();
        check("bp_no_extra", tx_q.size() - tx0, 2);
        $display("txn read with backpressure done");

        // Reset between DHI and DLO
        snap();
        send_byte(8'h57); send_byte(8'h05); send_byte(8'hAA);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_w_addr", {24'd0, w_addr_o}, 0);
        check("mid_rst_w_data", {16'd0, w_data_o}, 0);
        check("mid_rst_rx_ready", {31'd0, rx_ready_o}, 0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_release_ready", {31'd0, rx_ready_o}, 1);
        send_byte(8'h34);
        repeat (4) tick();
        check("mid_rst_no_we", we_cnt - we0, 0);
        check("mid_rst_no_tx", tx_q.size() - tx0, 0);
        check("mid_rst_stray_err", err_cnt - er0, 1);
        $display("txn reset mid-write done");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
